// File: rtl/ibex_id_sequencer_pkg.sv
// Shared types for the ID-stage instruction sequencer.
package ibex_id_sequencer_pkg;

   typedef enum logic {
      FIRST_CYCLE = 1'b0,
      MULTI_CYCLE = 1'b1
   } id_seq_state_e;

   typedef enum logic [2:0] {
      WAIT_NONE = 3'd0,
      WAIT_LSU  = 3'd1,
      WAIT_MD   = 3'd2,
      WAIT_BR   = 3'd3,
      WAIT_JMP  = 3'd4
   } id_wait_e;

endpackage

// File: rtl/ibex_id_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; usable for any perf counter.
module ibex_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   // Clear wins over increment; the count holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ibex_id_sequencer.sv
// ID-stage sequencer: walks one decoded instruction through its execute phases.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FIRST_CYCLE | new instruction in ID; single-cycle ops retire here
// MULTI_CYCLE | waiting on LSU / mult-div, or second cycle of branch/jump
module ibex_id_sequencer
   import ibex_id_sequencer_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 16,
   parameter bit          RV32M       = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   instr_valid_i,
   input  logic                   kill_i,
   input  logic                   illegal_insn_i,
   input  logic                   jump_in_dec_i,
   input  logic                   branch_in_dec_i,
   input  logic                   data_req_dec_i,
   input  logic                   mult_en_dec_i,
   input  logic                   div_en_dec_i,
   input  logic                   branch_decision_i,
   input  logic                   lsu_resp_valid_i,
   input  logic                   lsu_err_i,
   input  logic                   multdiv_valid_i,
   output logic                   instr_new_o,
   output logic                   lsu_req_o,
   output logic                   multdiv_en_o,
   output logic                   multdiv_kill_o,
   output logic                   branch_set_o,
   output logic                   id_ready_o,
   output logic                   lsu_exc_o,
   output logic                   stall_o,
   output logic [STALL_CNT_W-1:0] stall_cycles_o,
   input  logic                   stall_cnt_clr_i
);

   id_seq_state_e state_q, state_d;
   id_wait_e      wait_q, wait_d;
   logic          kill_seen_q, kill_seen_d;
   logic          start;
   logic          md_dec;
   logic          multi_done;

   assign start  = instr_valid_i && !kill_i && !illegal_insn_i;
   assign md_dec = (mult_en_dec_i || div_en_dec_i) && RV32M;

   // Condition that ends the MULTI_CYCLE phase for the current wait type.
   always_comb begin
      multi_done = 1'b1;
      case (wait_q)
         WAIT_LSU: multi_done = lsu_resp_valid_i;
         WAIT_MD:  multi_done = kill_i || multdiv_valid_i;
         default:  multi_done = 1'b1;
      endcase
   end

   // State, wait-type and recorded-kill registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= FIRST_CYCLE;
         wait_q      <= WAIT_NONE;
         kill_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         kill_seen_q <= kill_seen_d;
      end
   end

   // Next-state decode; decoder flags resolve LSU > MD > BR > JMP.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      kill_seen_d = kill_seen_q;
      case (state_q)
         FIRST_CYCLE: begin
            if (start) begin
               if (data_req_dec_i) begin
                  state_d = MULTI_CYCLE;
                  wait_d  = WAIT_LSU;
               end else if (md_dec) begin
                  state_d = MULTI_CYCLE;
                  wait_d  = WAIT_MD;
               end else if (branch_in_dec_i) begin
                  if (branch_decision_i) begin
                     state_d = MULTI_CYCLE;
                     wait_d  = WAIT_BR;
                  end
               end else if (jump_in_dec_i) begin
                  state_d = MULTI_CYCLE;
                  wait_d  = WAIT_JMP;
               end
            end
         end
         MULTI_CYCLE: begin
            if (multi_done) begin
               state_d     = FIRST_CYCLE;
               wait_d      = WAIT_NONE;
               kill_seen_d = 1'b0;
            end else if ((wait_q == WAIT_LSU) && kill_i) begin
               // A bus access cannot be recalled; remember the kill so the
               // eventual response retires silently.
               kill_seen_d = 1'b1;
            end
         end
         default: begin
            state_d = FIRST_CYCLE;
            wait_d  = WAIT_NONE;
         end
      endcase
   end

   // Output decode from state, wait type and the current-cycle inputs.
   always_comb begin
      lsu_req_o      = 1'b0;
      multdiv_en_o   = 1'b0;
      multdiv_kill_o = 1'b0;
      branch_set_o   = 1'b0;
      id_ready_o     = 1'b0;
      lsu_exc_o      = 1'b0;
      stall_o        = 1'b0;
      case (state_q)
         FIRST_CYCLE: begin
            if (instr_valid_i) begin
               if (!start) begin
                  id_ready_o = 1'b1;
               end else if (data_req_dec_i) begin
                  lsu_req_o = 1'b1;
               end else if (md_dec) begin
                  multdiv_en_o = 1'b1;
               end else if (branch_in_dec_i) begin
                  id_ready_o = !branch_decision_i;
               end else if (!jump_in_dec_i) begin
                  id_ready_o = 1'b1;
               end
            end
         end
         MULTI_CYCLE: begin
            stall_o = !multi_done;
            case (wait_q)
               WAIT_LSU: begin
                  id_ready_o = lsu_resp_valid_i;
                  lsu_exc_o  = lsu_resp_valid_i && lsu_err_i && !kill_seen_q && !kill_i;
               end
               WAIT_MD: begin
                  multdiv_en_o   = !kill_i;
                  multdiv_kill_o = kill_i;
                  id_ready_o     = kill_i || multdiv_valid_i;
               end
               WAIT_BR: begin
                  branch_set_o = !kill_i;
                  id_ready_o   = 1'b1;
               end
               default: begin
                  id_ready_o = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
   end

   assign instr_new_o = (state_q == FIRST_CYCLE);

   ibex_sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .inc   (stall_o),
      .clr   (stall_cnt_clr_i),
      .count (stall_cycles_o)
   );

endmodule

// File: tb/tb_ibex_id_sequencer.sv
// Directed bench for the ID sequencer; narrow stall counter to reach saturation.
module tb_ibex_id_sequencer;

   localparam int unsigned W = 4;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         instr_valid_i, kill_i, illegal_insn_i, jump_in_dec_i;
   logic         branch_in_dec_i, data_req_dec_i, mult_en_dec_i, div_en_dec_i;
   logic         branch_decision_i, lsu_resp_valid_i, lsu_err_i, multdiv_valid_i;
   logic         stall_cnt_clr_i;
   logic         instr_new_o, lsu_req_o, multdiv_en_o, multdiv_kill_o;
   logic         branch_set_o, id_ready_o, lsu_exc_o, stall_o;
   logic [W-1:0] stall_cycles_o;

   int checks = 0;
   int errors = 0;

   ibex_id_sequencer #(.STALL_CNT_W(W), .RV32M(1'b1)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .instr_valid_i     (instr_valid_i),
      .kill_i            (kill_i),
      .illegal_insn_i    (illegal_insn_i),
      .jump_in_dec_i     (jump_in_dec_i),
      .branch_in_dec_i   (branch_in_dec_i),
      .data_req_dec_i    (data_req_dec_i),
      .mult_en_dec_i     (mult_en_dec_i),
      .div_en_dec_i      (div_en_dec_i),
      .branch_decision_i (branch_decision_i),
      .lsu_resp_valid_i  (lsu_resp_valid_i),
      .lsu_err_i         (lsu_err_i),
      .multdiv_valid_i   (multdiv_valid_i),
      .instr_new_o       (instr_new_o),
      .lsu_req_o         (lsu_req_o),
      .multdiv_en_o      (multdiv_en_o),
      .multdiv_kill_o    (multdiv_kill_o),
      .branch_set_o      (branch_set_o),
      .id_ready_o        (id_ready_o),
      .lsu_exc_o         (lsu_exc_o),
      .stall_o           (stall_o),
      .stall_cycles_o    (stall_cycles_o),
      .stall_cnt_clr_i   (stall_cnt_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic idle();
      instr_valid_i = 0; kill_i = 0; illegal_insn_i = 0; jump_in_dec_i = 0;
      branch_in_dec_i = 0; data_req_dec_i = 0; mult_en_dec_i = 0; div_en_dec_i = 0;
      branch_decision_i = 0; lsu_resp_valid_i = 0; lsu_err_i = 0; multdiv_valid_i = 0;
      stall_cnt_clr_i = 0;
   endtask

   initial begin
      idle();
      rst_ni = 0;
      tick(); tick();
      rst_ni = 1;
      settle();
      check_eq("rst_instr_new", instr_new_o, 1);
      check_eq("rst_id_ready", id_ready_o, 0);
      check_eq("rst_stall", stall_o, 0);
      check_eq("rst_cnt", stall_cycles_o, 0);
      check_eq("rst_lsu_req", lsu_req_o, 0);

      // responses in FIRST_CYCLE with no instruction are ignored
      lsu_resp_valid_i = 1; lsu_err_i = 1; multdiv_valid_i = 1; settle();
      check_eq("idle_id_ready", id_ready_o, 0);
      check_eq("idle_lsu_exc", lsu_exc_o, 0);
      tick(); idle(); settle();
      check_eq("idle_stay", instr_new_o, 1);

      // ADD
      instr_valid_i = 1; settle();
      check_eq("add_ready", id_ready_o, 1);
      check_eq("add_new", instr_new_o, 1);
      check_eq("add_stall", stall_o, 0);
      tick(); idle(); settle();
      check_eq("add_cnt", stall_cycles_o, 0);
      check_eq("add_stay", instr_new_o, 1);

      // LW, response three cycles after request
      instr_valid_i = 1; data_req_dec_i = 1; settle();
      check_eq("lw_req", lsu_req_o, 1);
      check_eq("lw_ready0", id_ready_o, 0);
      tick(); idle(); settle();
      check_eq("lw_req1", lsu_req_o, 0);
      check_eq("lw_stall1", stall_o, 1);
      check_eq("lw_new1", instr_new_o, 0);
      tick(); settle();
      check_eq("lw_stall2", stall_o, 1);
      check_eq("lw_ready2", id_ready_o, 0);
      tick(); lsu_resp_valid_i = 1; settle();
      check_eq("lw_ready3", id_ready_o, 1);
      check_eq("lw_stall3", stall_o, 0);
      check_eq("lw_exc3", lsu_exc_o, 0);
      tick(); idle(); settle();
      check_eq("lw_new4", instr_new_o, 1);
      check_eq("lw_cnt", stall_cycles_o, 2);

      // LSU error at earliest legal response; also LSU beats MD/BR
      instr_valid_i = 1; data_req_dec_i = 1; mult_en_dec_i = 1; branch_in_dec_i = 1;
      branch_decision_i = 1; settle();
      check_eq("prio_lsu_req", lsu_req_o, 1);
      check_eq("prio_md_en", multdiv_en_o, 0);
      tick(); idle(); lsu_resp_valid_i = 1; lsu_err_i = 1; settle();
      check_eq("lerr_exc", lsu_exc_o, 1);
      check_eq("lerr_ready", id_ready_o, 1);
      check_eq("lerr_bset", branch_set_o, 0);
      tick(); idle(); stall_cnt_clr_i = 1; settle();
      check_eq("lerr_new", instr_new_o, 1);
      tick(); idle(); settle();
      check_eq("clr_cnt", stall_cycles_o, 0);

      // taken BEQ
      instr_valid_i = 1; branch_in_dec_i = 1; branch_decision_i = 1; settle();
      check_eq("bt_ready1", id_ready_o, 0);
      check_eq("bt_bset1", branch_set_o, 0);
      tick(); idle(); settle();
      check_eq("bt_bset2", branch_set_o, 1);
      check_eq("bt_ready2", id_ready_o, 1);
      check_eq("bt_stall2", stall_o, 0);
      tick(); settle();
      check_eq("bt_new3", instr_new_o, 1);
      check_eq("bt_bset3", branch_set_o, 0);

      // not-taken BEQ
      instr_valid_i = 1; branch_in_dec_i = 1; settle();
      check_eq("bn_ready", id_ready_o, 1);
      check_eq("bn_bset", branch_set_o, 0);
      tick(); idle(); settle();
      check_eq("bn_bset2", branch_set_o, 0);
      check_eq("bn_new2", instr_new_o, 1);

      // taken branch killed in its second cycle
      instr_valid_i = 1; branch_in_dec_i = 1; branch_decision_i = 1; settle();
      tick(); idle(); kill_i = 1; settle();
      check_eq("bk_bset", branch_set_o, 0);
      check_eq("bk_ready", id_ready_o, 1);
      tick(); idle(); settle();

      // JAL
      instr_valid_i = 1; jump_in_dec_i = 1; settle();
      check_eq("jmp_ready1", id_ready_o, 0);
      tick(); idle(); settle();
      check_eq("jmp_ready2", id_ready_o, 1);
      check_eq("jmp_new2", instr_new_o, 0);
      check_eq("jmp_stall2", stall_o, 0);
      tick(); settle();
      check_eq("jmp_new3", instr_new_o, 1);

      // illegal load: no enables, retire immediately
      instr_valid_i = 1; illegal_insn_i = 1; data_req_dec_i = 1; settle();
      check_eq("ill_req", lsu_req_o, 0);
      check_eq("ill_ready", id_ready_o, 1);
      tick(); idle(); settle();
      check_eq("ill_new", instr_new_o, 1);

      // MUL beats taken branch; finishes on multdiv_valid_i
      instr_valid_i = 1; mult_en_dec_i = 1; branch_in_dec_i = 1; branch_decision_i = 1; settle();
      check_eq("mb_en", multdiv_en_o, 1);
      check_eq("mb_ready", id_ready_o, 0);
      tick(); idle(); multdiv_valid_i = 1; settle();
      check_eq("mb_done_ready", id_ready_o, 1);
      check_eq("mb_bset", branch_set_o, 0);
      tick(); idle(); stall_cnt_clr_i = 1; settle();
      tick(); idle(); settle();

      // DIV killed in its 4th MULTI_CYCLE cycle; clear during stall wins
      instr_valid_i = 1; div_en_dec_i = 1; settle();
      check_eq("div_en0", multdiv_en_o, 1);
      tick(); idle(); settle();
      check_eq("div_en1", multdiv_en_o, 1);
      check_eq("div_stall1", stall_o, 1);
      tick(); stall_cnt_clr_i = 1; settle();
      check_eq("div_cnt2", stall_cycles_o, 1);
      tick(); stall_cnt_clr_i = 0; settle();
      check_eq("div_cnt3", stall_cycles_o, 0);
      tick(); kill_i = 1; settle();
      check_eq("div_cnt4", stall_cycles_o, 1);
      check_eq("div_kill", multdiv_kill_o, 1);
      check_eq("div_en4", multdiv_en_o, 0);
      check_eq("div_ready4", id_ready_o, 1);
      tick(); idle(); settle();
      check_eq("div_new5", instr_new_o, 1);
      check_eq("div_kill5", multdiv_kill_o, 0);

      // SW killed while waiting, error response arrives later
      instr_valid_i = 1; data_req_dec_i = 1; settle();
      check_eq("sw_req", lsu_req_o, 1);
      tick(); idle(); kill_i = 1; settle();
      check_eq("swk_stall1", stall_o, 1);
      check_eq("swk_ready1", id_ready_o, 0);
      tick(); idle(); settle();
      check_eq("swk_new2", instr_new_o, 0);
      check_eq("swk_stall2", stall_o, 1);
      tick(); lsu_resp_valid_i = 1; lsu_err_i = 1; settle();
      check_eq("swk_exc", lsu_exc_o, 0);
      check_eq("swk_ready3", id_ready_o, 1);
      tick(); idle(); stall_cnt_clr_i = 1; settle();
      check_eq("swk_new4", instr_new_o, 1);
      tick(); idle(); settle();

      // 20-cycle mult saturates the 4-bit counter
      instr_valid_i = 1; mult_en_dec_i = 1; settle();
      for (int k = 1; k <= 19; k++) begin
         tick(); idle(); settle();
         check_eq("sat_stall", stall_o, 1);
         check_eq("sat_cnt", stall_cycles_o, (k - 1 > 15) ? 15 : k - 1);
      end
      tick(); multdiv_valid_i = 1; settle();
      check_eq("sat_ready", id_ready_o, 1);
      tick(); idle(); settle();
      check_eq("sat_final", stall_cycles_o, 15);

      // reset in the middle of a mult
      instr_valid_i = 1; mult_en_dec_i = 1; settle();
      tick(); idle(); settle();
      tick(); settle();
      check_eq("mrst_stall", stall_o, 1);
      rst_ni = 0;
      tick(); settle();
      check_eq("mrst_new", instr_new_o, 1);
      check_eq("mrst_cnt", stall_cycles_o, 0);
      check_eq("mrst_stall2", stall_o, 0);
      check_eq("mrst_en", multdiv_en_o, 0);
      rst_ni = 1;
      tick(); settle();
      check_eq("mrst_cnt2", stall_cycles_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
